// File: rtl/bnn_inference_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bnn_inference_ctrl
// Description : Sequencer for a combinational binarized network. It gathers
//               the binary image byte-serially, holds it stable on image_o,
//               waits a programmable settle window, captures the class
//               scores and then finds the winning class one class per cycle.
//               Optional build macro BNN_CTRL_CYCLE_CNT_EN adds cycle_cnt_o,
//               a saturating start-to-done cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_inference_ctrl #(
  parameter int N_IN_BYTES = 8,
  parameter int N_CLASSES  = 10,
  parameter int SCORE_W    = 7,
  parameter int SETTLE_W   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic [SETTLE_W-1:0]            settle_cycles_i,
  input  logic                           load_valid_i,
  input  logic [7:0]                     load_data_i,
  output logic                           load_ready_o,
  output logic [8*N_IN_BYTES-1:0]        image_o,
  input  logic [N_CLASSES*SCORE_W-1:0]   scores_i,
  output logic [N_CLASSES*SCORE_W-1:0]   scores_o,
  output logic [3:0]                     class_o,
  output logic [SCORE_W-1:0]             max_score_o,
  output logic                           busy_o,
`ifdef BNN_CTRL_CYCLE_CNT_EN
  output logic                           done_o,
  output logic [15:0]                    cycle_cnt_o
`else
  output logic                           done_o
`endif
);

  localparam int IMG_W  = 8 * N_IN_BYTES;
  localparam int SC_W   = N_CLASSES * SCORE_W;
  localparam int BCNT_W = (N_IN_BYTES > 1) ? $clog2(N_IN_BYTES) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_ARGMAX  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]          state_q,      state_d;
  logic [BCNT_W-1:0]   byte_cnt_q,   byte_cnt_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [3:0]          idx_q,        idx_d;
  logic [3:0]          best_idx_q,   best_idx_d;
  logic [SCORE_W-1:0]  best_val_q,   best_val_d;
  logic [IMG_W-1:0]    image_q,      image_d;
  logic [SC_W-1:0]     scores_q,     scores_d;
  logic [3:0]          class_q,      class_d;
  logic [SCORE_W-1:0]  max_score_q,  max_score_d;
  logic                done_q,       done_d;
`ifdef BNN_CTRL_CYCLE_CNT_EN
  logic [15:0]         run_cnt_q,    run_cnt_d;
  logic [15:0]         cycle_cnt_q,  cycle_cnt_d;
`endif

  // Score of the class currently under evaluation in the argmax walk
  logic [SCORE_W-1:0] cur_score;
  assign cur_score = scores_q[int'(idx_q)*SCORE_W +: SCORE_W];

  // Next-state and datapath update; abort overrides every state
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    settle_cnt_d = settle_cnt_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_val_d   = best_val_q;
    image_d      = image_q;
    scores_d     = scores_q;
    class_d      = class_q;
    max_score_d  = max_score_q;
    done_d       = 1'b0;
`ifdef BNN_CTRL_CYCLE_CNT_EN
    run_cnt_d    = run_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    // The start cycle itself is counted, hence the count begins at 1
    if (state_q != ST_IDLE && run_cnt_q != 16'hFFFF) begin
      run_cnt_d = run_cnt_q + 16'd1;
    end
`endif
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d    = ST_LOAD;
            byte_cnt_d = '0;
`ifdef BNN_CTRL_CYCLE_CNT_EN
            run_cnt_d  = 16'd1;
`endif
          end
        end
        ST_LOAD: begin
          if (load_valid_i) begin
            image_d[int'(byte_cnt_q)*8 +: 8] = load_data_i;
            if (byte_cnt_q == BCNT_W'(N_IN_BYTES - 1)) begin
              state_d      = ST_SETTLE;
              byte_cnt_d   = '0;
              // A zero settle request still gives the network one cycle
              settle_cnt_d = (settle_cycles_i == '0) ? SETTLE_W'(1) : settle_cycles_i;
            end else begin
              byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q <= SETTLE_W'(1)) begin
            state_d      = ST_CAPTURE;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
          end
        end
        ST_CAPTURE: begin
          scores_d   = scores_i;
          best_idx_d = 4'd0;
          best_val_d = scores_i[SCORE_W-1:0];
          idx_d      = 4'd1;
          state_d    = ST_ARGMAX;
        end
        ST_ARGMAX: begin
          // Strict compare keeps the lowest index on ties
          if (cur_score > best_val_q) begin
            best_idx_d = idx_q;
            best_val_d = cur_score;
          end
          if (idx_q == 4'(N_CLASSES - 1)) begin
            idx_d   = 4'd0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        ST_DONE: begin
          class_d     = best_idx_q;
          max_score_d = best_val_q;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
`ifdef BNN_CTRL_CYCLE_CNT_EN
          cycle_cnt_d = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_cnt_q + 16'd1;
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and result registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      settle_cnt_q <= '0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_val_q   <= '0;
      image_q      <= '0;
      scores_q     <= '0;
      class_q      <= '0;
      max_score_q  <= '0;
      done_q       <= 1'b0;
`ifdef BNN_CTRL_CYCLE_CNT_EN
      run_cnt_q    <= '0;
      cycle_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_val_q   <= best_val_d;
      image_q      <= image_d;
      scores_q     <= scores_d;
      class_q      <= class_d;
      max_score_q  <= max_score_d;
      done_q       <= done_d;
`ifdef BNN_CTRL_CYCLE_CNT_EN
      run_cnt_q    <= run_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
`endif
    end
  end

  assign load_ready_o = (state_q == ST_LOAD);
  assign busy_o       = (state_q != ST_IDLE);
  assign image_o      = image_q;
  assign scores_o     = scores_q;
  assign class_o      = class_q;
  assign max_score_o  = max_score_q;
  assign done_o       = done_q;
`ifdef BNN_CTRL_CYCLE_CNT_EN
  assign cycle_cnt_o  = cycle_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bnn_inference_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bnn_inference_ctrl
// Description : Directed bench for bnn_inference_ctrl with a result
//               scoreboard checked whenever done_o pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_inference_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [3:0]  settle_cycles_i = '0;
  logic        load_valid_i = 1'b0;
  logic [7:0]  load_data_i = '0;
  logic        load_ready_o;
  logic [63:0] image_o;
  logic [69:0] scores_i = '0;
  logic [69:0] scores_o;
  logic [3:0]  class_o;
  logic [6:0]  max_score_o;
  logic        busy_o;
  logic        done_o;
`ifdef BNN_CTRL_CYCLE_CNT_EN
  logic [15:0] cycle_cnt_o;
`endif

  bnn_inference_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .settle_cycles_i(settle_cycles_i),
    .load_valid_i   (load_valid_i),
    .load_data_i    (load_data_i),
    .load_ready_o   (load_ready_o),
    .image_o        (image_o),
    .scores_i       (scores_i),
    .scores_o       (scores_o),
    .class_o        (class_o),
    .max_score_o    (max_score_o),
    .busy_o         (busy_o),
`ifdef BNN_CTRL_CYCLE_CNT_EN
    .done_o         (done_o),
    .cycle_cnt_o    (cycle_cnt_o)
`else
    .done_o         (done_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  cls;
    logic [6:0]  mx;
    logic [69:0] sc;
    int          lat;
    int          hs;
    int          cc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop and compare on every done pulse
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_ni && done_o) begin
      check("done_pulse_width", 128'(prev_done), 128'(0));
      if (sb.size() == 0) begin
        check("spurious_done", 128'(done_o), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        check("class_o", 128'(class_o), 128'(mon_e.cls));
        check("max_score_o", 128'(max_score_o), 128'(mon_e.mx));
        check("scores_o", 128'(scores_o), 128'(mon_e.sc));
        check("done_latency", 128'(cyc - mon_e.hs), 128'(mon_e.lat));
`ifdef BNN_CTRL_CYCLE_CNT_EN
        check("cycle_cnt_o", 128'(cycle_cnt_o), 128'(mon_e.cc));
`endif
      end
    end
    prev_done <= done_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run and stream all eight bytes; optional stall between bytes
  // and optional start_i held high while busy
  task automatic start_and_load(input logic [63:0] img, input logic [3:0] settle,
                                input bit stall, input bit spam,
                                output int st, output int hs);
    settle_cycles_i = settle;
    start_i = 1'b1;
    tick();
    start_i = spam;
    st = cyc;
    check("busy_after_start", 128'(busy_o), 128'(1));
    check("ready_in_load", 128'(load_ready_o), 128'(1));
    for (int k = 0; k < 8; k++) begin
      load_data_i  = img[k*8 +: 8];
      load_valid_i = 1'b1;
      tick();
      if (stall && k != 7) begin
        load_valid_i = 1'b0;
        tick();
      end
    end
    hs = cyc;
    load_valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", 128'(ok), 128'(1));
  endtask

  logic [69:0] sc1, sc2, sc3, sc4;
  logic [63:0] img1, img2, img3;
  int st, hs;

  initial begin
    for (int c = 0; c < 10; c++) begin
      sc1[c*7 +: 7] = 7'(c * 5);
      sc2[c*7 +: 7] = (c == 2 || c == 7) ? 7'd20 : 7'd10;
      sc3[c*7 +: 7] = (c == 4 || c == 9) ? 7'd127 : 7'd126;
      sc4[c*7 +: 7] = 7'd0;
    end
    img1 = 64'h0807060504030201;
    img2 = 64'hA7A6A5A4A3A2A1A0;
    img3 = 64'hDEADBEEF01234567;

    // Reset values
    #12;
    check("rst_image", 128'(image_o), 128'(0));
    check("rst_scores", 128'(scores_o), 128'(0));
    check("rst_class", 128'(class_o), 128'(0));
    check("rst_max", 128'(max_score_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_ready", 128'(load_ready_o), 128'(0));
    check("rst_done", 128'(done_o), 128'(0));
    tick();
    rst_ni = 1'b1;
    tick();
    tick();

    // Basic inference, settle 3
    scores_i = sc1;
    start_and_load(img1, 4'd3, 1'b0, 1'b0, st, hs);
    sb.push_back('{cls:4'd9, mx:7'd45, sc:sc1, lat:14, hs:hs, cc:hs - st + 15});
    check("basic_image", 128'(image_o), 128'(img1));
    check("basic_busy_settle", 128'(busy_o), 128'(1));
    wait_done();

    // Back-to-back start; ties and stalls; extra byte must be refused
    scores_i = sc2;
    start_and_load(img2, 4'd3, 1'b1, 1'b0, st, hs);
    sb.push_back('{cls:4'd2, mx:7'd20, sc:sc2, lat:14, hs:hs, cc:hs - st + 15});
    load_valid_i = 1'b1;
    load_data_i  = 8'hFF;
    tick();
    load_valid_i = 1'b0;
    check("tie_ready_after_load", 128'(load_ready_o), 128'(0));
    check("tie_image_8_bytes", 128'(image_o), 128'(img2));
    wait_done();
    tick();

    // Settle zero behaves as one; max score and tie with class 9
    scores_i = sc3;
    start_and_load(img3, 4'd0, 1'b0, 1'b0, st, hs);
    sb.push_back('{cls:4'd4, mx:7'd127, sc:sc3, lat:12, hs:hs, cc:hs - st + 13});
    wait_done();
    tick();

    // Abort in SETTLE: result registers keep the previous run
    scores_i = sc1;
    start_and_load(img1, 4'd5, 1'b0, 1'b0, st, hs);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_busy", 128'(busy_o), 128'(0));
    check("abort_class", 128'(class_o), 128'(4));
    check("abort_max", 128'(max_score_o), 128'(127));
    check("abort_scores", 128'(scores_o), 128'(sc3));
    check("abort_image", 128'(image_o), 128'(img1));
    repeat (20) tick();
    check("abort_idle", 128'(busy_o), 128'(0));

    // New run with start_i held while busy: exactly one result
    scores_i = sc4;
    start_and_load(img3, 4'd2, 1'b0, 1'b1, st, hs);
    sb.push_back('{cls:4'd0, mx:7'd0, sc:sc4, lat:13, hs:hs, cc:hs - st + 14});
    wait_done();
    repeat (30) tick();
    check("single_run_idle", 128'(busy_o), 128'(0));
    check("sb_drained", 128'(sb.size()), 128'(0));

    // start and abort together in IDLE: abort wins
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start_abort_idle", 128'(busy_o), 128'(0));

    // Asynchronous reset in the middle of ARGMAX
    scores_i = sc1;
    start_and_load(img2, 4'd3, 1'b0, 1'b0, st, hs);
    repeat (8) tick();
    check("argmax_busy", 128'(busy_o), 128'(1));
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_image", 128'(image_o), 128'(0));
    check("arst_scores", 128'(scores_o), 128'(0));
    check("arst_class", 128'(class_o), 128'(0));
    check("arst_max", 128'(max_score_o), 128'(0));
    check("arst_busy", 128'(busy_o), 128'(0));
    check("arst_done", 128'(done_o), 128'(0));
    sb.delete();
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", 128'(busy_o), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
